// File: rtl/proc_img_pkg.sv
// proc_img_pkg: shared image geometry and write-controller state type for the processed-image memory.
package proc_img_pkg;
    localparam int IMG_W     = 390;
    localparam int IMG_H     = 390;
    localparam int MEM_DEPTH = IMG_W * IMG_H;
    typedef enum logic [1:0] {IDLE, RUN, DONE} wr_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; priority passes to the other requester after every grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);
    logic [1:0] req;
    logic       pointer;
    always_comb begin
        req      = valid & eligible;
        grant[0] = req[0] & (~req[1] | ~pointer);
        grant[1] = req[1] & ~grant[0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pointer <= 1'b0;
        else if (|grant)
            pointer <= grant[0];
    end
endmodule

// File: rtl/processed_image_write_ctrl.sv
// processed_image_write_ctrl: arbitrates CPU and stream byte writes into the processed-image memory.
// Optional macro PROC_IMG_ADDR_CHECK_EN drops out-of-range CPU writes and raises sticky addr_err.
module processed_image_write_ctrl
    import proc_img_pkg::*;
#(
    parameter int MEM_DEPTH = proc_img_pkg::MEM_DEPTH,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 18
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              abort,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              WE,
    output logic [ADDR_W-1:0] wA,
    output logic [DATA_W-1:0] WD,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  pix_count,
    output logic              addr_err
);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(MEM_DEPTH - 1);

    wr_state_t  state, state_n;
    logic [1:0] grant;
    logic       addr_ok;
    logic       wr_en;

    rr_arbiter2 u_arb (
        .clk      (CLK),
        .rst_n    (RST_N),
        .valid    ({req1_valid, req0_valid}),
        .eligible ({RST_N && state == RUN && !abort, RST_N}),
        .grant    (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign busy       = state == RUN;
    assign frame_done = state == DONE;

`ifdef PROC_IMG_ADDR_CHECK_EN
    assign addr_ok = req0_addr < ADDR_W'(MEM_DEPTH);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            addr_err <= 1'b0;
        else if (grant[0] && !addr_ok)
            addr_err <= 1'b1;
        else if (state == IDLE && start)
            addr_err <= 1'b0;
    end
`else
    assign addr_ok  = 1'b1;
    assign addr_err = 1'b0;
`endif

    assign wr_en = grant[1] | (grant[0] & addr_ok);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN:     state_n = abort ? IDLE : (grant[1] && pix_count == LAST_PIX) ? DONE : RUN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            pix_count <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start)
                pix_count <= '0;
            else if (grant[1])
                pix_count <= pix_count + CNT_W'(1);
        end
    end

    // wA/WD keep their last value on idle cycles; only WE returns low
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WE <= 1'b0;
            wA <= '0;
            WD <= '0;
        end else begin
            WE <= wr_en;
            if (wr_en) begin
                wA <= grant[1] ? ADDR_W'(pix_count) : req0_addr;
                WD <= grant[1] ? req1_data : req0_data;
            end
        end
    end
endmodule
